aes_decrypt_128: RTL
====================

# aes_decrypt_128

Iterative AES-128 inverse cipher (FIPS-197 decryption). It is the receive-side counterpart of the encryption top and its key expansion. The block loads a 128-bit cipher key and expands it once into 11 stored round keys, one key per cycle. It then decrypts 128-bit ciphertext blocks one round per cycle, with valid/ready handshakes on the key, input and output sides.

## Interface
- `key_size`, default 128: key width in bits. Only 128 is legal; any other value is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `key_valid` in 1: a new key is presented.
- `key_ready` out 1: the block can accept a key.
- `key` in 256: shared key bus. Only bits [127:0] are used; bits [255:128] are ignored.
- `in_valid` in 1: a ciphertext block is presented.
- `in_ready` out 1: the block can accept a ciphertext block.
- `ciphertext` in 128: input block.
- `out_valid` out 1: plaintext is valid.
- `out_ready` in 1: the consumer accepts the plaintext.
- `plaintext` out 128: output block.
- `key_loaded` out 1: a full round-key set is stored.

## Operation
- Byte order follows FIPS-197: byte 0 is bits [127:120], and the state is column-major.
- FSM states and transitions:
  - IDLE → KEY_EXP on a key handshake (`key_valid && key_ready`).
  - KEY_EXP runs 10 cycles, then → READY.
  - READY → KEY_EXP on a key handshake.
  - READY → ROUND on a ciphertext handshake.
  - ROUND runs 10 cycles, then → DONE.
  - DONE → READY on `out_valid && out_ready`.
- `key_ready` is 1 in IDLE and READY, 0 otherwise.
- `in_ready` = (state == READY) && !`key_valid`. A key presented in READY therefore has priority over ciphertext.
- Key expansion:
  - On the key handshake, rk[0] ← key[127:0] and the counter i ← 1.
  - Each KEY_EXP cycle, rk[i] ← standard AES-128 expansion of rk[i-1] (RotWord, SubWord, rcon[i]) and i increments.
  - rk[10] is written in the 10th cycle.
  - `key_loaded` clears on the key handshake and sets on entry to READY.
- Decryption:
  - On the ciphertext handshake, st ← ciphertext ^ rk[10] and r ← 9.
  - ROUND cycle with r = 9..1: st ← InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[r]), then r decrements.
  - ROUND cycle with r = 0: st ← InvSubBytes(InvShiftRows(st)) ^ rk[0], then → DONE.
- `plaintext` is driven from the st register. It is stable and `out_valid` = 1 throughout DONE until the output handshake.
- Ignored inputs:
  - `in_valid` in IDLE, KEY_EXP, ROUND or DONE: no effect.
  - `key_valid` in KEY_EXP, ROUND or DONE: no effect.
- Reset, including mid-operation: all of the following are cleared and the FSM enters IDLE.
  - Outputs: `key_ready`=0 while reset is asserted, then 1 in IDLE; `in_ready`=0; `out_valid`=0; `plaintext`=0; `key_loaded`=0.
  - Internal: st=0, all rk=0, counters=0.
  - Any in-flight block is dropped, and a key must be reloaded.

## Timing
- A key handshake at edge E0 writes rk[1] at E1 and rk[10] at E10. The block is in READY from E10, and `in_ready` can be 1 in the cycle after E10.
- A ciphertext handshake at edge E0 performs the rounds at E1..E10. `out_valid`=1 from E10, giving a latency of 10 cycles from acceptance to valid.
- With `out_ready` held at 1, the output handshake occurs at E11. The earliest next ciphertext acceptance is at E12, so sustained throughput is one block per 12 cycles.
- No combinational path exists from any input to `out_valid` or `plaintext`.
- `in_ready` depends combinationally on `key_valid`. This is the only such input-to-output path.

## Structure
- Shared package `aes_pkg` holds:
  - the forward `sbox` and `inv_sbox` as 256×8 constant arrays;
  - the `rcon` constant array;
  - the FSM enum `dec_state_t`;
  - functions `xtime` and `gmul`, used by InvMixColumns with multipliers 0e, 0b, 0d and 09.
- One combinational sub-module, `aes_inv_round`, with inputs st, rk and a `last` flag and output next_st. It is instantiated once.
- Round keys are stored in an 11×128 register array inside `aes_decrypt_128`.

## Test plan
- FIPS-197 C.1 vector: load key 000102030405060708090a0b0c0d0e0f, send ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a → plaintext 00112233445566778899aabbccddeeff, with `out_valid` exactly 10 cycles after acceptance.
- FIPS-197 Appendix B vector: load key 2b7e151628aed2a6abf7158809cf4f3c → internal rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6. Send ciphertext 3925841d02dc09fbdc118597196a0b32 → plaintext 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid` → `plaintext` stays constant and `in_ready`=0 throughout. Release `out_ready` → exactly one output handshake, then return to READY.
- Priority: in READY, assert `key_valid` and `in_valid` in the same cycle → the key is accepted, the ciphertext is not. After the 10-cycle re-expansion, decrypting a block with the new key gives the correct plaintext.
- Reset mid-round: assert `reset` during round 5 → all outputs read 0 and `key_loaded`=0. After release, `in_valid` is ignored until a key is reloaded.
- Back-to-back: load one key, decrypt three blocks consecutively with `out_ready`=1 → every result is correct, with a 12-cycle spacing between blocks.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the decryption block.
package aes_pkg;

    // Controller states of the iterative inverse cipher.
    typedef enum logic [2:0] {
        IDLE,
        KEY_EXP,
        READY,
        ROUND,
        DONE
    } dec_state_t;

    // Forward S-box, used by the key expansion (entry 0 is the leftmost byte).
    localparam logic [0:255][7:0] sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, used by InvSubBytes.
    localparam logic [0:255][7:0] inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Round constants; index i is the constant used to derive round key i.
    localparam logic [0:10][7:0] rcon = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_decrypt_128_if.sv
// Key, ciphertext and plaintext handshake bundle of the AES-128 decryptor.
interface aes_decrypt_128_if;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         key_loaded;

    modport master (
        output key_valid, key, in_valid, ciphertext, out_ready,
        input  key_ready, in_ready, out_valid, plaintext, key_loaded
    );

    modport slave (
        input  key_valid, key, in_valid, ciphertext, out_ready,
        output key_ready, in_ready, out_valid, plaintext, key_loaded
    );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the last round skips InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_st
);

    logic [7:0] sub [16];
    logic [7:0] ark [16];
    logic [7:0] mix [16];

    // InvShiftRows + InvSubBytes: byte (row r, col c) comes from column (c - r) mod 4.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub[4*c + r] = inv_sbox[st[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]];
            end
        end
    end

    // AddRoundKey on the substituted state.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ark[i] = sub[i] ^ rk[127 - 8*i -: 8];
        end
    end

    // InvMixColumns, one column at a time.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mix[4*c + 0] = gmul(ark[4*c], 8'h0e) ^ gmul(ark[4*c+1], 8'h0b)
                         ^ gmul(ark[4*c+2], 8'h0d) ^ gmul(ark[4*c+3], 8'h09);
            mix[4*c + 1] = gmul(ark[4*c], 8'h09) ^ gmul(ark[4*c+1], 8'h0e)
                         ^ gmul(ark[4*c+2], 8'h0b) ^ gmul(ark[4*c+3], 8'h0d);
            mix[4*c + 2] = gmul(ark[4*c], 8'h0d) ^ gmul(ark[4*c+1], 8'h09)
                         ^ gmul(ark[4*c+2], 8'h0e) ^ gmul(ark[4*c+3], 8'h0b);
            mix[4*c + 3] = gmul(ark[4*c], 8'h0b) ^ gmul(ark[4*c+1], 8'h0d)
                         ^ gmul(ark[4*c+2], 8'h09) ^ gmul(ark[4*c+3], 8'h0e);
        end
    end

    // Repack the bytes, choosing the final-round form when last is set.
    always_comb begin
        next_st = '0;
        for (int i = 0; i < 16; i++) begin
            next_st[127 - 8*i -: 8] = last ? ark[i] : mix[i];
        end
    end

endmodule

// File: rtl/aes_decrypt_128.sv
// Iterative AES-128 inverse cipher: one-time key expansion into 11 stored
// round keys, then one inverse round per cycle.
module aes_decrypt_128
    import aes_pkg::*;
#(
    parameter int key_size = 128
) (
    input  logic             clk,
    input  logic             reset,
    aes_decrypt_128_if.slave bus
);

    generate
        if (key_size != 128) begin : g_bad_key_size
            $error("aes_decrypt_128: key_size must be 128");
        end
    endgenerate

    dec_state_t   state;
    dec_state_t   state_next;
    logic [127:0] rk [0:10];
    logic [127:0] st;
    logic [127:0] next_st;
    logic [127:0] expanded;
    logic [3:0]   key_cnt;
    logic [3:0]   rnd_cnt;
    logic         key_loaded;
    logic         key_ready;
    logic         in_ready;
    logic         out_valid;
    logic         key_hs;
    logic         in_hs;
    logic         out_hs;
    logic         key_unused;

    // The upper half of the shared key bus carries nothing for AES-128.
    assign key_unused = ^bus.key[255:128];

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // One AES-128 key-schedule step: next four words from the previous four.
    function automatic logic [127:0] expand_key(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign expanded = expand_key(rk[key_cnt - 4'd1], rcon[key_cnt]);

    assign key_hs = bus.key_valid && key_ready;
    assign in_hs  = bus.in_valid && in_ready;
    assign out_hs = out_valid && bus.out_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: the default hold assignment keeps this block free of inferred latches.
        state_next = state;
        case (state)
            IDLE:    if (key_hs) state_next = KEY_EXP;
            KEY_EXP: if (key_cnt == 4'd10) state_next = READY;
            READY: begin
                if (key_hs)     state_next = KEY_EXP;
                else if (in_hs) state_next = ROUND;
            end
            ROUND:   if (rnd_cnt == 4'd0) state_next = DONE;
            DONE:    if (out_hs) state_next = READY;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs; a pending key in READY blocks ciphertext acceptance.
    always_comb begin
        key_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:  key_ready = !reset;
            READY: begin
                key_ready = !reset;
                in_ready  = !bus.key_valid;
            end
            DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Round-key store: rk[0] on key acceptance, then one expanded key per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the key store is cleared by reset so that no key material survives it.
            for (int i = 0; i < 11; i++) rk[i] <= '0;
            key_cnt    <= '0;
            key_loaded <= 1'b0;
        end else if (key_hs) begin
            rk[0]      <= bus.key[127:0];
            key_cnt    <= 4'd1;
            key_loaded <= 1'b0;
        end else if (state == KEY_EXP) begin
            rk[key_cnt] <= expanded;
            if (key_cnt == 4'd10) begin
                key_cnt    <= '0;
                key_loaded <= 1'b1;
            end else begin
                key_cnt <= key_cnt + 4'd1;
            end
        end
    end

    // Cipher state: initial whitening with rk[10], then rounds 9 down to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= '0;
            rnd_cnt <= '0;
        end else if (in_hs) begin
            st      <= bus.ciphertext ^ rk[10];
            rnd_cnt <= 4'd9;
        end else if (state == ROUND) begin
            st <= next_st;
            if (rnd_cnt != 4'd0) rnd_cnt <= rnd_cnt - 4'd1;
        end
    end

    aes_inv_round u_inv_round (
        .st      (st),
        .rk      (rk[rnd_cnt]),
        .last    (rnd_cnt == 4'd0),
        .next_st (next_st)
    );

    assign bus.key_ready  = key_ready;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.plaintext  = st;
    assign bus.key_loaded = key_loaded;

endmodule
